cache_rd_arbiter: RTL and testbench

CACHE_RD_ARBITER -- requirements
Module: cache_rd_arbiter

---
 rtl/cache_axi_pkg.sv | 16 +
 rtl/cache_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_cache_rd_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache read-path AXI arbiter: FSM encoding,
// burst type and default port IDs.
package cache_axi_pkg;

  localparam int         AXI_LEN_W    = 4;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam int         DEF_S0_ID    = 0;
  localparam int         DEF_S1_ID    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter merging i-cache (s0) and d-cache (s1) burst reads onto
// one AXI read master, with a single burst outstanding at a time.
//
// state | meaning
// IDLE  | no burst; arbitrate and latch the winner's request
// ADDR  | m_arvalid high with latched fields, waiting for m_arready
// DATA  | beats routed between m R channel and the granted port until rlast
module cache_rd_arbiter
  import cache_axi_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int S0_ID = DEF_S0_ID,
  parameter int S1_ID = DEF_S1_ID
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          s0_araddr,
  input  logic [AXI_LEN_W-1:0] s0_arlen,
  input  logic [2:0]           s0_arsize,
  input  logic                 s0_arvalid,
  output logic                 s0_arready,
  output logic [31:0]          s0_rdata,
  output logic                 s0_rlast,
  output logic                 s0_rvalid,
  input  logic                 s0_rready,
  input  logic [31:0]          s1_araddr,
  input  logic [AXI_LEN_W-1:0] s1_arlen,
  input  logic [2:0]           s1_arsize,
  input  logic                 s1_arvalid,
  output logic                 s1_arready,
  output logic [31:0]          s1_rdata,
  output logic                 s1_rlast,
  output logic                 s1_rvalid,
  input  logic                 s1_rready,
  output logic [ID_W-1:0]      m_arid,
  output logic [31:0]          m_araddr,
  output logic [AXI_LEN_W-1:0] m_arlen,
  output logic [2:0]           m_arsize,
  output logic [1:0]           m_arburst,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [ID_W-1:0]      m_rid,
  input  logic [31:0]          m_rdata,
  input  logic                 m_rlast,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  output logic                 proto_err
);

  state_e               r_state;
  logic                 r_last_grant;
  logic                 r_grant;
  logic [31:0]          r_addr;
  logic [AXI_LEN_W-1:0] r_len;
  logic [2:0]           r_size;
  logic [ID_W-1:0]      r_id;
  logic [AXI_LEN_W-1:0] r_beat_cnt;
  logic                 r_proto_err;

  logic w_pick;
  logic w_in_addr;
  logic w_in_data;
  logic w_ar_hs;
  logic w_s_rready;
  logic w_r_hs;
  logic w_len_err;
  logic w_id_err;
  logic w_fwd0;
  logic w_fwd1;

  // On a tie the port not served last wins; a lone requester always wins.
  assign w_pick     = (s0_arvalid & s1_arvalid) ? ~r_last_grant : s1_arvalid;
  assign w_in_addr  = (r_state == ST_ADDR);
  assign w_in_data  = (r_state == ST_DATA);
  assign w_ar_hs    = w_in_addr & m_arready;
  assign w_s_rready = r_grant ? s1_rready : s0_rready;
  assign w_r_hs     = m_rvalid & m_rready;
  assign w_len_err  = m_rlast ? (r_beat_cnt != r_len) : (r_beat_cnt == r_len);
  assign w_id_err   = (m_rid != r_id);
  assign w_fwd0     = w_in_data & ~r_grant;
  assign w_fwd1     = w_in_data & r_grant;

  assign m_arvalid  = w_in_addr;
  assign m_arid     = w_in_addr ? r_id   : '0;
  assign m_araddr   = w_in_addr ? r_addr : '0;
  assign m_arlen    = w_in_addr ? r_len  : '0;
  assign m_arsize   = w_in_addr ? r_size : '0;
  assign m_arburst  = w_in_addr ? ARBURST_INCR : 2'b00;
  assign m_rready   = w_in_data & w_s_rready;

  assign s0_arready = w_ar_hs & ~r_grant;
  assign s1_arready = w_ar_hs & r_grant;
  assign s0_rvalid  = w_fwd0 & m_rvalid;
  assign s1_rvalid  = w_fwd1 & m_rvalid;
  assign s0_rlast   = w_fwd0 & m_rlast;
  assign s1_rlast   = w_fwd1 & m_rlast;
  assign s0_rdata   = w_fwd0 ? m_rdata : '0;
  assign s1_rdata   = w_fwd1 ? m_rdata : '0;
  assign proto_err  = r_proto_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_id         <= '0;
      r_beat_cnt   <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s0_arvalid | s1_arvalid) begin
            r_state <= ST_ADDR;
            r_grant <= w_pick;
            r_addr  <= w_pick ? s1_araddr : s0_araddr;
            r_len   <= w_pick ? s1_arlen  : s0_arlen;
            r_size  <= w_pick ? s1_arsize : s0_arsize;
            r_id    <= w_pick ? ID_W'(S1_ID) : ID_W'(S0_ID);
          end
        end
        ST_ADDR: begin
          if (m_arready) begin
            r_state    <= ST_DATA;
            r_beat_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_len_err | w_id_err) r_proto_err <= 1'b1;
            // Only rlast ends the burst, even after a length mismatch.
            if (m_rlast) begin
              r_state      <= ST_IDLE;
              r_last_grant <= r_grant;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Scoreboard bench for cache_rd_arbiter: AXI slave model pushes expected
// beats, a negedge monitor pops and compares them at the granted port.
module tb_cache_rd_arbiter;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     s0_araddr = '0, s1_araddr = '0;
  logic [3:0]      s0_arlen = '0, s1_arlen = '0;
  logic [2:0]      s0_arsize = '0, s1_arsize = '0;
  logic            s0_arvalid = 1'b0, s1_arvalid = 1'b0;
  logic            s0_arready, s1_arready;
  logic [31:0]     s0_rdata, s1_rdata;
  logic            s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
  logic            s0_rready = 1'b1, s1_rready = 1'b1;
  logic [ID_W-1:0] m_arid;
  logic [31:0]     m_araddr;
  logic [3:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
  logic [ID_W-1:0] m_rid = '0;
  logic [31:0]     m_rdata = '0;
  logic            m_rlast = 1'b0, m_rvalid = 1'b0;
  logic            m_rready;
  logic            proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;

  cache_rd_arbiter #(.ID_W(ID_W), .S0_ID(0), .S1_ID(1)) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ar_rdy(input int p);
    return (p == 0) ? s0_arready : s1_arready;
  endfunction

  task automatic pop_check(input int port, input logic [31:0] d, input logic l, input logic other_rv);
    beat_t e;
    chk("sb_has_entry", 64'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("beat_port", port, e.port);
      chk("beat_data", d, e.data);
      chk("beat_last", l, e.last);
    end
    chk("other_rvalid", other_rv, 0);
  endtask

  always @(negedge clk) begin
    if (s0_rvalid && s0_rready) pop_check(0, s0_rdata, s0_rlast, s1_rvalid);
    if (s1_rvalid && s1_rready) pop_check(1, s1_rdata, s1_rlast, s0_rvalid);
  end

  task automatic master_req(input int p, input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz);
    bit got = 0;
    if (p == 0) begin
      s0_araddr = a; s0_arlen = len; s0_arsize = sz; s0_arvalid = 1'b1;
    end else begin
      s1_araddr = a; s1_arlen = len; s1_arsize = sz; s1_arvalid = 1'b1;
    end
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      #2;
      got = ar_rdy(p);
    end
    chk("ar_grant_seen", got, 1);
    tick();
    if (p == 0) s0_arvalid = 1'b0;
    else        s1_arvalid = 1'b0;
  endtask

  task automatic slave_burst(input int port, input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] sz, input logic [31:0] base,
                             input int nbeats, input int last_idx, input int stall,
                             input logic [ID_W-1:0] rid);
    bit    seen = 0;
    beat_t b;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = m_arvalid;
    end
    chk("ar_valid_seen", seen, 1);
    chk("ar_id", m_arid, id);
    chk("ar_addr", m_araddr, addr);
    chk("ar_len", m_arlen, len);
    chk("ar_size", m_arsize, sz);
    chk("ar_burst", m_arburst, 2'b01);
    chk("ar_ready_hold", ar_rdy(port), 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ar_stall_valid", m_arvalid, 1);
      chk("ar_stall_addr", m_araddr, addr);
      chk("ar_stall_ready", ar_rdy(port), 0);
    end
    m_arready = 1'b1;
    #1;
    chk("ar_ready_pulse", ar_rdy(port), 1);
    tick();
    m_arready = 1'b0;
    chk("ar_ready_after", ar_rdy(port), 0);
    for (int i = 0; i < nbeats; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = base + 32'(i);
      m_rlast  = (i == last_idx);
      m_rid    = rid;
      b.port = port;
      b.data = base + 32'(i);
      b.last = (i == last_idx);
      sb.push_back(b);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_s0_arready", s0_arready, 0);
    chk("rst_s1_arready", s1_arready, 0);
    chk("rst_s0_rvalid", s0_rvalid, 0);
    chk("rst_s1_rvalid", s1_rvalid, 0);
    chk("rst_proto_err", proto_err, 0);
    tick();

    // s1 alone, 8-beat burst
    fork
      master_req(1, 32'h0000_1000, 4'd7, 3'd2);
      slave_burst(1, 1, 32'h0000_1000, 4'd7, 3'd2, 32'hA0, 8, 7, 0, 1);
    join
    chk("a_proto_err", proto_err, 0);

    // simultaneous requests after reset: s0 first, s1 two cycles after rlast
    do_reset();
    fork
      master_req(0, 32'h2000, 4'd3, 3'd2);
      master_req(1, 32'h3000, 4'd3, 3'd2);
      begin
        slave_burst(0, 0, 32'h2000, 4'd3, 3'd2, 32'hB0, 4, 3, 0, 0);
        chk("rlast_next_arvalid", m_arvalid, 0);
        tick();
        chk("rlast_2cyc_arvalid", m_arvalid, 1);
        chk("rlast_2cyc_arid", m_arid, 1);
        slave_burst(1, 1, 32'h3000, 4'd3, 3'd2, 32'hC0, 4, 3, 0, 1);
      end
    join
    chk("b_proto_err", proto_err, 0);

    // back-to-back re-requests alternate by round-robin
    fork
      begin
        master_req(1, 32'h4000, 4'd3, 3'd2);
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (s1_rvalid && s1_rlast && s1_rready) break;
        end
        tick();
        master_req(1, 32'h6000, 4'd1, 3'd2);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        master_req(0, 32'h5000, 4'd2, 3'd2);
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (s0_rvalid && s0_rlast && s0_rready) break;
        end
        tick();
        master_req(0, 32'h7000, 4'd0, 3'd2);
      end
      begin
        slave_burst(1, 1, 32'h4000, 4'd3, 3'd2, 32'h100, 4, 3, 0, 1);
        slave_burst(0, 0, 32'h5000, 4'd2, 3'd2, 32'h200, 3, 2, 0, 0);
        slave_burst(1, 1, 32'h6000, 4'd1, 3'd2, 32'h300, 2, 1, 0, 1);
        slave_burst(0, 0, 32'h7000, 4'd0, 3'd2, 32'h400, 1, 0, 0, 0);
      end
    join
    chk("c_proto_err", proto_err, 0);

    // m_arready stalled 5 cycles
    fork
      master_req(1, 32'h8000, 4'd3, 3'd2);
      slave_burst(1, 1, 32'h8000, 4'd3, 3'd2, 32'h500, 4, 3, 5, 1);
    join
    chk("d_proto_err", proto_err, 0);

    // early rlast on beat 6 of 8
    fork
      master_req(0, 32'h9000, 4'd7, 3'd2);
      slave_burst(0, 0, 32'h9000, 4'd7, 3'd2, 32'hE0, 6, 5, 0, 0);
    join
    chk("e_proto_err", proto_err, 1);
    chk("e_idle_rready", m_rready, 0);
    chk("e_idle_arvalid", m_arvalid, 0);
    tick();
    chk("e_proto_sticky", proto_err, 1);

    // reset after 3 of 8 beats
    fork
      master_req(0, 32'hA000, 4'd7, 3'd2);
      slave_burst(0, 0, 32'hA000, 4'd7, 3'd2, 32'h600, 3, -1, 0, 0);
    join
    chk("g_in_data", m_rready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("g_arvalid", m_arvalid, 0);
    chk("g_rready", m_rready, 0);
    chk("g_s0_rlast", s0_rlast, 0);
    chk("g_proto_err", proto_err, 0);
    m_rvalid = 1'b1;
    #1;
    chk("g_idle_s0_rvalid", s0_rvalid, 0);
    chk("g_idle_s1_rvalid", s1_rvalid, 0);
    m_rvalid = 1'b0;
    tick();
    fork
      master_req(0, 32'hB000, 4'd3, 3'd2);
      slave_burst(0, 0, 32'hB000, 4'd3, 3'd2, 32'h700, 4, 3, 0, 0);
    join
    chk("g_after_proto_err", proto_err, 0);

    // wrong m_rid on an otherwise well-formed burst
    fork
      master_req(1, 32'hF000, 4'd1, 3'd2);
      slave_burst(1, 1, 32'hF000, 4'd1, 3'd2, 32'hF0, 2, 1, 0, 4'h5);
    join
    chk("f_rid_proto_err", proto_err, 1);

    repeat (3) tick();
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
